// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC selection: JALR target (LSB cleared) over branch/JAL target over PC+4.
module ifu_next_pc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  input  logic        jalr,
  output logic [31:0] next_pc
);

  logic [31:0] branch_target_s;
  logic [31:0] seq_target_s;

  assign branch_target_s = pc + imm_ext;
  assign seq_target_s    = pc + PC_INCR;

  always_comb begin
    next_pc = seq_target_s;
    if (jalr) begin
      next_pc = {alu_result[31:1], 1'b0};
    end else if (branch_taken) begin
      next_pc = branch_target_s;
    end else begin
      next_pc = seq_target_s;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns pc, fetches over req/ack, holds instr for decode.
// Optional IFU_MISALIGN_TRAP_EN: a misaligned next_pc traps to ERROR instead of being word-aligned.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        branch_taken,
  input  logic        jalr,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        fetch_err
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  ifu_state_e        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       next_pc_s;

  ifu_next_pc u_next_pc (
    .pc           (pc_q),
    .imm_ext      (imm_ext),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .jalr         (jalr),
    .next_pc      (next_pc_s)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      VALID: begin
        if (instr_ready) begin
`ifdef IFU_MISALIGN_TRAP_EN
          pc_d = next_pc_s;
          if (is_word_aligned(next_pc_s)) begin
            state_d = FETCH;
            wait_d  = '0;
          end else begin
            state_d = ERROR;
          end
`else
          pc_d    = next_pc_s & ~32'd3;
          state_d = FETCH;
          wait_d  = '0;
`endif
        end else begin
          state_d = VALID;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pc, held instruction and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == VALID);
  assign fetch_err   = (state_q == ERROR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default parameters).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        branch_taken;
  logic        jalr;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .branch_taken (branch_taken),
    .jalr         (jalr),
    .imm_ext      (imm_ext),
    .alu_result   (alu_result),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jalr         = 1'b0;
    imm_ext      = 32'h0;
    alu_result   = 32'h0;
  endtask

  // From FETCH: ack with word, then accept with the given control inputs.
  task automatic fetch_accept(input logic [31:0] word, input logic br, input logic jr,
                              input logic [31:0] imm, input logic [31:0] alu);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    branch_taken = br;
    jalr         = jr;
    imm_ext      = imm;
    alu_result   = alu;
    step();
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err",   {31'd0, fetch_err},   32'd0);
    chk("rst_pc",    pc,                   32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_instr", instr,                32'h0000_0013);

    rst_n = 1'b1;
    step();
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         32'h0);

    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    chk("ack_valid", {31'd0, instr_valid}, 32'd1);
    chk("ack_instr", instr,                32'h0050_0093);
    chk("ack_noreq", {31'd0, imem_req},    32'd0);

    // Stall in VALID; a stray ack must not overwrite instr.
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_instr", instr,                32'h0050_0093);
      chk("hold_pc",    pc,                   32'h0);
      chk("hold_req",   {31'd0, imem_req},    32'd0);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("seq_addr", imem_addr,         32'h4);
    chk("seq_req",  {31'd0, imem_req}, 32'd1);

    fetch_accept(32'h0000_0013, 1'b0, 1'b1, 32'h0, 32'h0000_0100);
    chk("jalr_100", imem_addr, 32'h100);
    fetch_accept(32'h0000_0013, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("branch_back", imem_addr, 32'h0F0);
    fetch_accept(32'h0000_0013, 1'b0, 1'b1, 32'h0, 32'h0000_0040);
    chk("jalr_40", imem_addr, 32'h40);
    fetch_accept(32'h0000_0013, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0201);
    chk("jalr_prio", imem_addr, 32'h200);
    fetch_accept(32'h0000_0013, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    fetch_accept(32'h0000_0013, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req",  {31'd0, imem_req}, 32'd1);

    // Controls asserted outside VALID must be ignored.
    instr_ready  = 1'b1;
    branch_taken = 1'b1;
    imm_ext      = 32'h0000_0080;
    step();
    clear_inputs();
    chk("ign_ready", pc, 32'h0);

    fetch_accept(32'h0000_0013, 1'b1, 1'b0, 32'h0000_0002, 32'h0);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc",  pc,                 32'h2);
    chk("mis_req", {31'd0, imem_req},  32'd0);
`else
    chk("mis_err",  {31'd0, fetch_err}, 32'd0);
    chk("mis_addr", imem_addr,          32'h0);
    chk("mis_req",  {31'd0, imem_req},  32'd1);
`endif

    // Reset in the middle of a fetch drops the in-flight ack.
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr,                32'h0000_0013);
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    chk("to_fetch", {31'd0, imem_req}, 32'd1);

    // No ack: FETCH lasts 15 cycles, ERROR on the 16th.
    for (int i = 0; i < 14; i++) begin
      step();
    end
    chk("to_pre_err", {31'd0, fetch_err}, 32'd0);
    chk("to_pre_req", {31'd0, imem_req},  32'd1);
    step();
    chk("to_err",   {31'd0, fetch_err},   32'd1);
    chk("to_noreq", {31'd0, imem_req},    32'd0);
    chk("to_noval", {31'd0, instr_valid}, 32'd0);

    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("err_clear", {31'd0, fetch_err}, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
